// File: rtl/exp_mul_scheduler.sv
// exp_mul_scheduler
//   Round-robin scheduler that lets NREQ requesters share one exponent adder
//   and one external mantissa multiplier. It accepts one operand pair, pulses
//   the multiplier start, waits for its done, then forms the biased exponent
//   sum (corrected by the mantissa twoormore flag) and returns it with the
//   owning requester id and tiny/huge flags. One multiply is in flight at a time.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready [NREQ]      per-requester handshake (at most one ready)
//   req_expa/req_expb               packed exponents, lane i at [i*WEXPSUM +: WEXPSUM]
//   mul_start                       one-cycle start pulse to the mantissa multiplier
//   mul_done, mul_twoormore         multiplier completion and product-in-[2,4) flag
//   out_valid/out_ready             result handshake
//   out_id, out_expsum              owning requester and wrapped exponent sum
//   out_tiny, out_huge              underflow / overflow indications
//   busy                            scheduler not idle
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | arbitrate; req_ready to the round-robin winner
// ISSUE  | mul_start pulse for the accepted operand pair
// WAIT   | wait for mul_done, then register result and flags
// RESP   | out_valid held until out_ready
module exp_mul_scheduler #(
  parameter int NREQ    = 4,
  parameter int WEXPSUM = 10,
  parameter int BIAS    = 127,
  parameter int EMAXP1  = 255,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WEXPSUM-1:0] req_expa,
  input  logic [NREQ*WEXPSUM-1:0] req_expb,
  output logic                    mul_start,
  input  logic                    mul_done,
  input  logic                    mul_twoormore,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDW-1:0]          out_id,
  output logic [WEXPSUM-1:0]      out_expsum,
  output logic                    out_tiny,
  output logic                    out_huge,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     id_q;
  logic [WEXPSUM-1:0] psum_q;

  logic               grant_vld;
  logic [IDW-1:0]     grant_id;
  logic [WEXPSUM-1:0] sel_expa, sel_expb;
  logic [WEXPSUM-1:0] res_sum;
  logic               res_tiny, res_huge;
  logic [IDW-1:0]     ptr_next;

  // Scan from the pointer upward, wrapping; first valid lane wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign sel_expa = req_expa[grant_id*WEXPSUM +: WEXPSUM];
  assign sel_expb = req_expb[grant_id*WEXPSUM +: WEXPSUM];

  assign res_sum  = psum_q + {{(WEXPSUM-1){1'b0}}, mul_twoormore};
  // Sign set means negative; all-zero magnitude bits with sign clear is zero.
  assign res_tiny = res_sum[WEXPSUM-1] | ~|res_sum[WEXPSUM-2:0];
  assign res_huge = ~res_sum[WEXPSUM-1] & (res_sum >= WEXPSUM'(EMAXP1));

  assign ptr_next = (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    mul_start = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        // Gated by rst_n so no lane sees an accept while reset is asserted.
        if (grant_vld && rst_n) begin
          req_ready[grant_id] = 1'b1;
          state_d             = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) state_d = S_RESP;
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      id_q       <= '0;
      psum_q     <= '0;
      out_expsum <= '0;
      out_tiny   <= 1'b0;
      out_huge   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            id_q   <= grant_id;
            psum_q <= sel_expa + sel_expb - WEXPSUM'(BIAS);
          end
        end
        S_WAIT: begin
          if (mul_done) begin
            out_expsum <= res_sum;
            out_tiny   <= res_tiny;
            out_huge   <= res_huge;
          end
        end
        S_RESP: begin
          if (out_ready) ptr_q <= ptr_next;
        end
        default: ;
      endcase
    end
  end

  assign out_id = id_q;

endmodule
